// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and limits for the multi-channel clock generator
package clk_gen_pkg;

    localparam int DIV_W_MAX = 32;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clk_gen_channel.sv
// rtl/clk_gen_channel.sv - one programmable square-wave channel with rise/fall strobes
module clk_gen_channel
    import clk_gen_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             sync,
    output logic             out_clk,
    output logic             rise,
    output logic             fall,
    output logic             busy
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            div_act_q <= DIV_W'(DIV_RST);
            out_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        out_d     = out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (!enable) begin
            // Disable wins over sync and terminal count; a high output closes with a fall.
            state_d = CH_IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            fall_d  = out_q;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    state_d   = CH_RUN;
                    div_act_d = div;
                    cnt_d     = '0;
                    out_d     = 1'b0;
                end
                CH_RUN: begin
                    // Sync restarts the phase; a zero divisor parks the channel and keeps re-sampling.
                    if (sync || div_act_q == '0) begin
                        cnt_d     = '0;
                        out_d     = 1'b0;
                        div_act_d = div;
                        fall_d    = out_q;
                    end else if (cnt_q == div_act_q - DIV_W'(1)) begin
                        cnt_d  = '0;
                        out_d  = ~out_q;
                        rise_d = ~out_q;
                        fall_d = out_q;
                        if (out_q) begin
                            div_act_d = div;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: state_d = CH_IDLE;
            endcase
        end
        busy_d = enable && (div_act_d != '0);
    end

    assign out_clk = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = busy_q;

endmodule

// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - NCH independent programmable clock/tick channels with common sync
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic                 sync,
    output logic [NCH-1:0]       out_clk,
    output logic [NCH-1:0]       rise,
    output logic [NCH-1:0]       fall,
    output logic [NCH-1:0]       busy
);

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        clk_gen_channel #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable[n]),
            .div     (div[n*DIV_W +: DIV_W]),
            .sync    (sync),
            .out_clk (out_clk[n]),
            .rise    (rise[n]),
            .fall    (fall[n]),
            .busy    (busy[n])
        );
    end

endmodule
